alu5_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for one shared 5-bit ALU (ports a, b, op -> R, cf, sf, zf).
- Accepts one operation at a time over a valid/ready handshake and registers the operands onto the ALU inputs.
- Captures the ALU result and flags after one execute cycle and returns them to the granted requester over a valid/ready response handshake.
- Sits between the CPU's issue logic (requester 0) and the auxiliary/address unit (requester 1) and the ALU_5bit instance.

---
 rtl/alu5_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu5_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu5_arbiter.sv
// Round-robin arbiter/sequencer placing two requesters onto one shared 5-bit ALU.
// Each operation takes IDLE (accept), EXEC (ALU evaluates), and DONE (hold response until consumed).

module alu5_arb_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             done,
  output logic             vld,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      cnt <= '0;
    end else if (set) begin
      vld <= 1'b1;
    end else if (done) begin
      vld <= 1'b0;
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

module alu5_arbiter #(
  parameter int W     = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [1:0]       req0_op,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [1:0]       req1_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  input  logic [W-1:0]     alu_r,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [W-1:0]     rsp_r,
  output logic             rsp_cf,
  output logic             rsp_sf,
  output logic             rsp_zf,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
  } req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nx;
  req_t   req [NUM_REQ];
  req_t   sel;
  logic   last, grant, winner;
  logic   accept, cap, done;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt;

  assign req[0] = '{a: req0_a, b: req0_b, op: req0_op};
  assign req[1] = '{a: req1_a, b: req1_b, op: req1_op};

  // On contention the requester that did not finish last wins.
  assign winner = (&req_valid) ? ~last : req_valid[1];
  assign sel    = req[winner];
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    cap       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (|req_valid) begin
        req_ready = winner ? 2'b10 : 2'b01;
        accept    = 1'b1;
        state_nx  = EXEC;
      end
      EXEC: begin
        cap      = 1'b1;
        state_nx = DONE;
      end
      DONE: if (rsp_ready[grant]) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 2'b00;
      grant  <= 1'b0;
      last   <= 1'b1;
      rsp_r  <= '0;
      rsp_cf <= 1'b0;
      rsp_sf <= 1'b0;
      rsp_zf <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= sel.a;
        alu_b  <= sel.b;
        alu_op <= sel.op;
        grant  <= winner;
      end
      if (cap) begin
        rsp_r  <= alu_r;
        rsp_cf <= alu_cf;
        rsp_sf <= alu_sf;
        rsp_zf <= alu_zf;
      end
      if (done) last <= grant;
    end
  end

  // Per-requester response-valid flag and completion counter.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    alu5_arb_lane #(.CNT_W(CNT_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .set  (cap  && (grant == 1'(i))),
      .done (done && (grant == 1'(i))),
      .vld  (rsp_valid[i]),
      .cnt  (cnt[i])
    );
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
endmodule

// File: tb/tb_alu5_arbiter.sv
// Directed bench for alu5_arbiter with a stub adder ALU; a second CNT_W=2 copy checks counter wrap.

module tb_alu5_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, rsp_ready;
  logic [4:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;

  logic [1:0] req_ready, alu_op, rsp_valid;
  logic [4:0] alu_a, alu_b, alu_r, rsp_r;
  logic       alu_cf, alu_sf, alu_zf, rsp_cf, rsp_sf, rsp_zf, busy;
  logic [7:0] cnt0, cnt1;

  logic [1:0] req_ready2, alu_op2, rsp_valid2;
  logic [4:0] alu_a2, alu_b2, alu_r2, rsp_r2;
  logic       alu_cf2, alu_sf2, alu_zf2, rsp_cf2, rsp_sf2, rsp_zf2, busy2;
  logic [1:0] cnt0_2, cnt1_2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Stub ALU: every opcode adds.
  assign {alu_cf, alu_r}   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_sf            = alu_r[4];
  assign alu_zf            = (alu_r == 5'd0);
  assign {alu_cf2, alu_r2} = {1'b0, alu_a2} + {1'b0, alu_b2};
  assign alu_sf2           = alu_r2[4];
  assign alu_zf2           = (alu_r2 == 5'd0);

  alu5_arbiter #(.W(5), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
    .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  alu5_arbiter #(.W(5), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2),
    .alu_r(alu_r2), .alu_cf(alu_cf2), .alu_sf(alu_sf2), .alu_zf(alu_zf2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_r(rsp_r2),
    .rsp_cf(rsp_cf2), .rsp_sf(rsp_sf2), .rsp_zf(rsp_zf2),
    .busy(busy2), .cnt0(cnt0_2), .cnt1(cnt1_2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // One full operation from the accept cycle; leaves the bench in the following IDLE cycle.
  task automatic op(input string tag, input logic [1:0] eg, input logic [4:0] ea, input logic [4:0] eb,
                    input logic [4:0] er, input logic [2:0] eflg);
    chk({tag, ".rdy"}, 32'(req_ready), 32'(eg));
    step();
    chk({tag, ".busy_x"}, 32'(busy), 32'd1);
    chk({tag, ".rdy_x"}, 32'(req_ready), 32'd0);
    chk({tag, ".alu_a"}, 32'(alu_a), 32'(ea));
    chk({tag, ".alu_b"}, 32'(alu_b), 32'(eb));
    chk({tag, ".vld_x"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, ".vld_d"}, 32'(rsp_valid), 32'(eg));
    chk({tag, ".r"}, 32'(rsp_r), 32'(er));
    chk({tag, ".flg"}, 32'({rsp_cf, rsp_sf, rsp_zf}), 32'(eflg));
    step();
    chk({tag, ".busy_i"}, 32'(busy), 32'd0);
    chk({tag, ".vld_i"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = 2'b11;
    rst_n = 1'b0;
    step();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.vld", 32'(rsp_valid), 32'd0);
    chk("rst.alu_a", 32'(alu_a), 32'd0);
    chk("rst.r", 32'(rsp_r), 32'd0);
    chk("rst.cnt", 32'({cnt0, cnt1}), 32'd0);

    // T1 single op
    do_reset();
    req_valid = 2'b01; rsp_ready = 2'b01;
    req0_a = 5'b10101; req0_b = 5'b10001; #1;
    op("t1", 2'b01, 5'b10101, 5'b10001, 5'b00110, 3'b100);
    chk("t1.cnt0", 32'(cnt0), 32'd1);
    req_valid = 2'b00;

    // T2 contention
    do_reset();
    req0_a = 5'd1; req0_b = 5'd2; req1_a = 5'd31; req1_b = 5'd1;
    req_valid = 2'b11; rsp_ready = 2'b11; #1;
    op("t2a", 2'b01, 5'd1, 5'd2, 5'd3, 3'b000);
    op("t2b", 2'b10, 5'd31, 5'd1, 5'd0, 3'b101);
    chk("t2.cnt0", 32'(cnt0), 32'd1);
    chk("t2.cnt1", 32'(cnt1), 32'd1);

    // T3 fairness
    do_reset(); #1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) op("t3", 2'b01, 5'd1, 5'd2, 5'd3, 3'b000);
      else            op("t3", 2'b10, 5'd31, 5'd1, 5'd0, 3'b101);
    end
    chk("t3.cnt0", 32'(cnt0), 32'd3);
    chk("t3.cnt1", 32'(cnt1), 32'd3);

    // T4 backpressure, including a stray rsp_ready on the other requester
    req_valid = 2'b00;
    do_reset();
    req0_a = 5'b01000; req0_b = 5'b01000;
    req_valid = 2'b01; rsp_ready = 2'b00; #1;
    chk("t4.rdy", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b11;
    step();
    chk("t4.vld", 32'(rsp_valid), 32'b01);
    chk("t4.r", 32'(rsp_r), 32'b10000);
    chk("t4.sf", 32'(rsp_sf), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 2'b10;
      step();
      chk("t4.hold_vld", 32'(rsp_valid), 32'b01);
      chk("t4.hold_r", 32'(rsp_r), 32'b10000);
      chk("t4.hold_sf", 32'(rsp_sf), 32'd1);
      chk("t4.hold_rdy", 32'(req_ready), 32'd0);
      chk("t4.hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 2'b01;
    req_valid = 2'b00;
    step();
    chk("t4.busy", 32'(busy), 32'd0);
    chk("t4.vld_i", 32'(rsp_valid), 32'd0);
    chk("t4.cnt", 32'({cnt1, cnt0}), 32'd1);

    // T5 reset during EXEC
    do_reset();
    req0_a = 5'd1; req0_b = 5'd2;
    req_valid = 2'b11; rsp_ready = 2'b11; #1;
    op("t5a", 2'b01, 5'd1, 5'd2, 5'd3, 3'b000);
    step();
    chk("t5.exec", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.vld", 32'(rsp_valid), 32'd0);
    chk("t5.alu_a", 32'(alu_a), 32'd0);
    chk("t5.cnt", 32'({cnt0, cnt1}), 32'd0);
    step();
    rst_n = 1'b1; #1;
    op("t5b", 2'b01, 5'd1, 5'd2, 5'd3, 3'b000);

    // T6 counter wrap on the CNT_W=2 copy
    req_valid = 2'b00;
    do_reset();
    req0_a = 5'd3; req0_b = 5'd4;
    req_valid = 2'b01; rsp_ready = 2'b01; #1;
    for (int i = 0; i < 5; i++) begin
      op("t6", 2'b01, 5'd3, 5'd4, 5'd7, 3'b000);
      chk("t6.cnt0_w", 32'(cnt0_2), 32'((i + 1) % 4));
      chk("t6.cnt0", 32'(cnt0), 32'(i + 1));
    end
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
